// File: rtl/data_mem_pkg.sv
// Shared encodings for data_mem_sized: access sizes, FSM state type, alignment rule.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_misaligned(logic [1:0] sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select with sign/zero extension; little-endian lanes.
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte/half/word data memory with WAIT_CYC wait states and a one-cycle ready pulse.
// DATA_MEM_TEST_EN exposes word 0 [15:0] on test_value; otherwise test_value is tied low.
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        w_e,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] w_d,
  output logic [31:0] r_d,
  output logic        ready,
  output logic        busy,
  output logic        misalign,
  output logic [15:0] test_value
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q, mis_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wd_q, rd_q;

  logic          exec, mis_now;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdat, ld_dat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_CYC);
      end
      ST_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
               else               state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign exec    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mis_now = is_misaligned(size_q, addr_q[1:0]);
  assign idx     = addr_q[AW+1:2];

  always_comb begin
    be   = 4'b0000;
    wdat = wd_q;
    case (size_q)
      SZ_BYTE: begin be = 4'b0001 << addr_q[1:0]; wdat = {4{wd_q[7:0]}}; end
      SZ_HALF: begin be = addr_q[1] ? 4'b1100 : 4'b0011; wdat = {2{wd_q[15:0]}}; end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  load_align u_load_align (
    .word_i (mem[idx]),
    .size_i (size_q),
    .off_i  (addr_q[1:0]),
    .uns_i  (uns_q),
    .data_o (ld_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        we_q   <= w_e;
        size_q <= size;
        uns_q  <= uns;
        addr_q <= addr;
        wd_q   <= w_d;
      end
      if (exec) begin
        mis_q <= mis_now;
        if (!we_q && !mis_now) rd_q <= ld_dat;
      end else if (state_q == ST_DONE) begin
        mis_q <= 1'b0;
      end
    end
  end

  // Memory is never reset; an aborted access never reaches exec.
  always_ff @(posedge clk) begin
    if (exec && we_q && !mis_now) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  assign r_d      = rd_q;
  assign ready    = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign misalign = mis_q;

`ifdef DATA_MEM_TEST_EN
  assign test_value = mem[0][15:0];
`else
  assign test_value = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_sized.sv
// Randomized bench for data_mem_sized against a byte-array reference model.
module tb_data_mem_sized;

  localparam int DEPTH    = 256;
  localparam int WAIT_CYC = 1;
  localparam int NBYTES   = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        w_e = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] w_d = 32'd0;
  logic [31:0] r_d;
  logic        ready, busy, misalign;
  logic [15:0] test_value;

  int errs = 0;
  int checks = 0;

  logic [7:0]  mb [NBYTES];
  logic [31:0] rd_exp = 32'd0;

  always #5 clk = ~clk;

  data_mem_sized #(.DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .w_e(w_e), .size(size), .uns(uns),
    .addr(addr), .w_d(w_d), .r_d(r_d), .ready(ready), .busy(busy),
    .misalign(misalign), .test_value(test_value)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_tv();
`ifdef DATA_MEM_TEST_EN
    return {mb[1], mb[0]};
`else
    return 16'h0000;
`endif
  endfunction

  task automatic access(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int base, n;
    logic mis;
    logic [31:0] v;
    base = int'(a[9:2]) * 4;
    mis  = model_mis(sz, a);
    @(negedge clk);
    req = 1'b1; w_e = we; size = sz; uns = u; addr = a; w_d = wd;
    @(posedge clk);
    #1;
    req = 1'b0; w_e = $urandom; addr = $urandom; w_d = $urandom;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (n <= 20) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
    end
    check("ready_latency", n, WAIT_CYC + 1);
    check("misalign", {31'd0, misalign}, {31'd0, mis});
    if (!mis) begin
      if (we) begin
        if (sz == 2'd0) mb[base + int'(a[1:0])] = wd[7:0];
        else if (sz == 2'd1) begin
          mb[base + (a[1] ? 2 : 0)]     = wd[7:0];
          mb[base + (a[1] ? 3 : 1)]     = wd[15:8];
        end else begin
          for (int i = 0; i < 4; i++) mb[base + i] = wd[8*i +: 8];
        end
      end else begin
        if (sz == 2'd0) begin
          v = {24'd0, mb[base + int'(a[1:0])]};
          if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = {16'd0, mb[base + (a[1] ? 3 : 1)], mb[base + (a[1] ? 2 : 0)]};
          if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
          v = {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
        end
        rd_exp = v;
      end
    end
    check("r_d", r_d, rd_exp);
    @(posedge clk);
    #1;
    check("ready_one_cycle", {30'd0, ready, busy}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_outputs", {29'd0, ready, busy, misalign}, 32'd0);
    check("rst_r_d", r_d, 32'd0);
    rst = 1'b0;

    // Give every word a defined value so random loads are always checkable.
    for (int w = 0; w < DEPTH; w++) access(1'b1, 2'd2, 1'b0, w * 4, $urandom);
    check("test_value_init", {16'd0, test_value}, {16'd0, model_tv()});

    access(1'b1, 2'd2, 1'b0, 32'h14, 32'h0000_1234);
    access(1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
    check("sw_lw_14", r_d, 32'h0000_1234);

    access(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_00AB);
    access(1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
    check("sb_lw_14", r_d, 32'h0000_AB34);
    access(1'b0, 2'd0, 1'b0, 32'h15, 32'd0);
    check("lb_15", r_d, 32'hFFFF_FFAB);
    access(1'b0, 2'd0, 1'b1, 32'h15, 32'd0);
    check("lbu_15", r_d, 32'h0000_00AB);

    access(1'b1, 2'd2, 1'b0, 32'h14, 32'h8000_0000);
    access(1'b0, 2'd1, 1'b0, 32'h16, 32'd0);
    check("lh_16", r_d, 32'hFFFF_8000);
    access(1'b0, 2'd1, 1'b1, 32'h16, 32'd0);
    check("lhu_16", r_d, 32'h0000_8000);
    access(1'b0, 2'd2, 1'b0, 32'h414, 32'd0);
    check("lw_alias_414", r_d, 32'h8000_0000);

    access(1'b1, 2'd2, 1'b0, 32'h16, 32'h1111_2222);
    access(1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
    check("mis_store_no_write", r_d, 32'h8000_0000);
    access(1'b0, 2'd3, 1'b0, 32'h14, 32'd0);
    check("illegal_keeps_r_d", r_d, 32'h8000_0000);

    // Abort a store mid-WAIT with an asynchronous reset pulse.
    access(1'b0, 2'd2, 1'b0, 32'h18, 32'd0);
    @(negedge clk);
    req = 1'b1; w_e = 1'b1; size = 2'd2; addr = 32'h18; w_d = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy_rst", {30'd0, ready, busy}, 32'd0);
    check("abort_r_d_rst", r_d, 32'd0);
    rd_exp = 32'd0;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_ready", {30'd0, ready, busy}, 32'd0);
    end
    access(1'b0, 2'd2, 1'b0, 32'h18, 32'd0);

    access(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE_1234);
    check("test_value_cafe", {16'd0, test_value}, {16'd0, model_tv()});

    for (int i = 0; i < 300; i++) begin
      access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom);
    end
    check("test_value_end", {16'd0, test_value}, {16'd0, model_tv()});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errs++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end

endmodule
